// File: rtl/lcd_spi_frame_writer.sv
// lcd_spi_frame_writer: sends a panel reset, an init script and one solid red
// RGB565 frame to an ILI9341-class LCD through the iCE40UP5K SB_SPI system bus.
module lcd_spi_frame_writer #(
  parameter logic [15:0] DIS_RES_X        = 16'd240,
  parameter logic [15:0] DIS_RES_Y        = 16'd320,
  parameter int unsigned HW_RESET_TIMER   = 1200000,
  parameter int unsigned SW_RESET_TIMER   = 600000,
  parameter int unsigned SLEEP_OUT_TIMER  = 600000,
  parameter int unsigned DISPLAY_ON_TIMER = 600000,
  parameter int unsigned SPI_CLK_DIVIDER  = 1,
  parameter logic [3:0]  SPI_ADDR_BASE    = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       spi_strobe,
  output logic       spi_rw,
  output logic [7:0] spi_reg_addr,
  output logic [7:0] spi_data_in,
  input  logic [7:0] spi_data_out,
  input  logic       spi_ack,
  output logic       dis_reset,
  output logic       dc,
  output logic       tx_busy
);

  localparam logic [7:0]  REG_CR1   = {SPI_ADDR_BASE, 4'h9};
  localparam logic [7:0]  REG_CR2   = {SPI_ADDR_BASE, 4'hA};
  localparam logic [7:0]  REG_BR    = {SPI_ADDR_BASE, 4'hB};
  localparam logic [7:0]  REG_SR    = {SPI_ADDR_BASE, 4'hC};
  localparam logic [7:0]  REG_TXDR  = {SPI_ADDR_BASE, 4'hD};
  localparam logic [7:0]  TRDY_MASK = 8'h10;
  localparam logic [7:0]  BR_VAL    = 8'(SPI_CLK_DIVIDER - 1);
  localparam logic [31:0] HW_LIM    = 32'(HW_RESET_TIMER - 1);
  localparam logic [31:0] PIX_LAST  = {16'h0, DIS_RES_X} * {16'h0, DIS_RES_Y} - 32'd1;
  localparam logic [4:0]  SCR_LAST  = 5'd17;

  // Script entry: {post-wait select, is_data, byte}; wait 0 = none.
  function automatic logic [10:0] script_entry(input logic [4:0] i);
    case (i)
      5'd0:    script_entry = {2'd1, 1'b0, 8'h01};
      5'd1:    script_entry = {2'd2, 1'b0, 8'h11};
      5'd2:    script_entry = {2'd0, 1'b0, 8'h3A};
      5'd3:    script_entry = {2'd0, 1'b1, 8'h55};
      5'd4:    script_entry = {2'd0, 1'b0, 8'h36};
      5'd5:    script_entry = {2'd0, 1'b1, 8'h48};
      5'd6:    script_entry = {2'd3, 1'b0, 8'h29};
      5'd7:    script_entry = {2'd0, 1'b0, 8'h2A};
      5'd8:    script_entry = {2'd0, 1'b1, 8'h00};
      5'd9:    script_entry = {2'd0, 1'b1, 8'h00};
      5'd10:   script_entry = {2'd0, 1'b1, DIS_RES_X[15:8]};
      5'd11:   script_entry = {2'd0, 1'b1, DIS_RES_X[7:0]};
      5'd12:   script_entry = {2'd0, 1'b0, 8'h2B};
      5'd13:   script_entry = {2'd0, 1'b1, 8'h00};
      5'd14:   script_entry = {2'd0, 1'b1, 8'h00};
      5'd15:   script_entry = {2'd0, 1'b1, DIS_RES_Y[15:8]};
      5'd16:   script_entry = {2'd0, 1'b1, DIS_RES_Y[7:0]};
      5'd17:   script_entry = {2'd0, 1'b0, 8'h2C};
      default: script_entry = {2'd0, 1'b0, 8'h00};
    endcase
  endfunction

  function automatic logic [31:0] delay_limit(input logic [1:0] sel);
    case (sel)
      2'd1:    delay_limit = 32'(SW_RESET_TIMER - 1);
      2'd2:    delay_limit = 32'(SLEEP_OUT_TIMER - 1);
      default: delay_limit = 32'(DISPLAY_ON_TIMER - 1);
    endcase
  endfunction

  typedef enum logic [2:0] {M_CFG1, M_CFG2, M_CFG3, M_IDLE, M_POLL, M_TX} m_state_t;
  typedef enum logic [2:0] {S_HW0, S_HW1, S_SETUP, S_SEND, S_WAIT, S_DELAY, S_DONE} s_state_t;

  m_state_t    m_state, m_state_nxt, req_next;
  logic        strobe_nxt, tx_accept, tx_start, req_rw;
  logic [7:0]  req_addr, req_data, tx_data, tx_byte;

  s_state_t    s_state, s_state_nxt;
  logic [31:0] cnt, cnt_nxt, pix_cnt, pix_cnt_nxt;
  logic [4:0]  idx, idx_nxt;
  logic        pix_mode, pix_mode_nxt, pix_phase, pix_phase_nxt;
  logic        dc_nxt, dis_reset_nxt, adv;
  logic [10:0] entry;
  logic        cur_kind;
  logic [7:0]  cur_byte;

  assign tx_busy = (m_state != M_IDLE);

  // Bus transaction each master state wants to run, and where it goes on ack.
  always_comb begin
    req_rw   = 1'b1;
    req_addr = REG_CR1;
    req_data = 8'h80;
    req_next = m_state;
    case (m_state)
      M_CFG1: begin req_addr = REG_CR1;  req_data = 8'h80;   req_next = M_CFG2; end
      M_CFG2: begin req_addr = REG_CR2;  req_data = 8'hC0;   req_next = M_CFG3; end
      M_CFG3: begin req_addr = REG_BR;   req_data = BR_VAL;  req_next = M_IDLE; end
      M_POLL: begin
        req_rw   = 1'b0;
        req_addr = REG_SR;
        req_data = 8'h00;
        req_next = (|(spi_data_out & TRDY_MASK)) ? M_TX : M_POLL;
      end
      M_TX:   begin req_addr = REG_TXDR; req_data = tx_byte; req_next = M_IDLE; end
      default: ;
    endcase
  end

  // Bus master sequencing: strobe up, wait for ack, strobe down for a cycle.
  always_comb begin
    m_state_nxt = m_state;
    strobe_nxt  = spi_strobe;
    tx_accept   = 1'b0;
    if (m_state == M_IDLE) begin
      if (tx_start) begin
        tx_accept   = 1'b1;
        m_state_nxt = M_POLL;
      end
    end else if (!spi_strobe) begin
      strobe_nxt = 1'b1;
    end else if (spi_ack) begin
      strobe_nxt  = 1'b0;
      m_state_nxt = req_next;
    end
  end

  // Bus master control state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state    <= M_CFG1;
      spi_strobe <= 1'b0;
    end else begin
      m_state    <= m_state_nxt;
      spi_strobe <= strobe_nxt;
    end
  end

  // Bus fields load only while strobe is low so they stay frozen until ack.
  always_ff @(posedge clk) begin
    if (!spi_strobe) begin
      spi_rw       <= req_rw;
      spi_reg_addr <= req_addr;
      spi_data_in  <= req_data;
    end
    if (tx_accept) tx_byte <= tx_data;
  end

  assign entry    = script_entry(idx);
  assign cur_kind = pix_mode ? 1'b1 : entry[8];
  assign cur_byte = pix_mode ? (pix_phase ? 8'h00 : 8'hF8) : entry[7:0];

  // Display sequencer: panel reset, script bytes with waits, then pixels.
  always_comb begin
    s_state_nxt   = s_state;
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    pix_mode_nxt  = pix_mode;
    pix_phase_nxt = pix_phase;
    pix_cnt_nxt   = pix_cnt;
    dc_nxt        = dc;
    dis_reset_nxt = dis_reset;
    tx_start      = 1'b0;
    tx_data       = cur_byte;
    adv           = 1'b0;
    case (s_state)
      S_HW0, S_HW1: begin
        dis_reset_nxt = (s_state == S_HW1);
        if (cnt == HW_LIM) begin
          cnt_nxt       = 32'd0;
          dis_reset_nxt = 1'b1;
          s_state_nxt   = (s_state == S_HW0) ? S_HW1 : S_SETUP;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      S_SETUP: begin
        dc_nxt      = cur_kind;
        s_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start    = 1'b1;
          s_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!tx_busy) begin
          if (!pix_mode && entry[10:9] != 2'd0) begin
            cnt_nxt     = 32'd0;
            s_state_nxt = S_DELAY;
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_DELAY: begin
        if (cnt == delay_limit(entry[10:9])) adv = 1'b1;
        else cnt_nxt = cnt + 32'd1;
      end
      default: ;
    endcase
    if (adv) begin
      cnt_nxt     = 32'd0;
      s_state_nxt = S_SETUP;
      if (pix_mode) begin
        if (!pix_phase) begin
          pix_phase_nxt = 1'b1;
        end else if (pix_cnt == PIX_LAST) begin
          s_state_nxt = S_DONE;
        end else begin
          pix_phase_nxt = 1'b0;
          pix_cnt_nxt   = pix_cnt + 32'd1;
        end
      end else if (idx == SCR_LAST) begin
        pix_mode_nxt  = 1'b1;
        pix_phase_nxt = 1'b0;
        pix_cnt_nxt   = 32'd0;
      end else begin
        idx_nxt = idx + 5'd1;
      end
    end
  end

  // Sequencer state, timers and panel pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_state   <= S_HW0;
      cnt       <= 32'd0;
      idx       <= 5'd0;
      pix_mode  <= 1'b0;
      pix_phase <= 1'b0;
      pix_cnt   <= 32'd0;
      dc        <= 1'b0;
      dis_reset <= 1'b0;
    end else begin
      s_state   <= s_state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      pix_mode  <= pix_mode_nxt;
      pix_phase <= pix_phase_nxt;
      pix_cnt   <= pix_cnt_nxt;
      dc        <= dc_nxt;
      dis_reset <= dis_reset_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_spi_frame_writer.sv
// Bench for lcd_spi_frame_writer: SB_SPI bus model plus write scoreboard.
module tb_lcd_spi_frame_writer;
  localparam logic [15:0] X = 16'd4;
  localparam logic [15:0] Y = 16'd3;
  localparam int LIMIT = 20000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       spi_strobe, spi_rw, dis_reset, dc, tx_busy;
  logic [7:0] spi_reg_addr, spi_data_in;
  logic [7:0] spi_data_out = 8'h00;
  logic       spi_ack = 1'b0;

  lcd_spi_frame_writer #(
    .DIS_RES_X(X), .DIS_RES_Y(Y), .HW_RESET_TIMER(100), .SW_RESET_TIMER(5),
    .SLEEP_OUT_TIMER(5), .DISPLAY_ON_TIMER(5), .SPI_CLK_DIVIDER(1), .SPI_ADDR_BASE(4'h0)
  ) dut (
    .clk(clk), .reset(reset), .spi_strobe(spi_strobe), .spi_rw(spi_rw),
    .spi_reg_addr(spi_reg_addr), .spi_data_in(spi_data_in), .spi_data_out(spi_data_out),
    .spi_ack(spi_ack), .dis_reset(dis_reset), .dc(dc), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // expected writes: {dc, addr, data}
  logic [16:0] sb[$];
  int cyc = 0, ack_dly = 2, poll_zero = 0, wcnt = 0, low_cnt = 1;
  int tx_writes = 0, txn_starts = 0, sr_reads = 0, reads_first = -1;
  int rise_cyc = -1, first_tx_cyc = -1, rel_cyc = 0;
  logic in_txn = 1'b0, stable = 1'b1, last_trdy = 1'b0, prev_dis = 1'b0, just_acked;
  logic [16:0] cap, expv;

  always @(posedge clk) cyc++;

  // SB_SPI model, evaluated on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (!reset) begin
      spi_ack = 1'b0; in_txn = 1'b0; wcnt = 0; low_cnt = 1; prev_dis = dis_reset;
    end else begin
      if (dis_reset && !prev_dis) rise_cyc = cyc;
      prev_dis = dis_reset;
      just_acked = spi_ack;
      spi_ack = 1'b0;
      if (just_acked) check("strobe_drop", spi_strobe, 0);
      if (spi_strobe && !just_acked) begin
        if (!in_txn) begin
          check("strobe_gap", low_cnt >= 1, 1);
          in_txn = 1'b1; wcnt = 0; stable = 1'b1; txn_starts++;
          cap = {spi_rw, spi_reg_addr, spi_data_in};
        end else if ({spi_rw, spi_reg_addr, spi_data_in} != cap) begin
          stable = 1'b0;
        end
        low_cnt = 0;
        wcnt++;
        if (wcnt >= ack_dly) begin
          spi_ack = 1'b1; in_txn = 1'b0;
          check("hold_stable", stable, 1);
          if (!spi_rw) begin
            check("rd_addr", spi_reg_addr, 8'h0C);
            check("busy_poll", tx_busy, 1);
            sr_reads++;
            if (poll_zero > 0) begin
              spi_data_out = 8'h00; poll_zero--; last_trdy = 1'b0;
            end else begin
              spi_data_out = 8'h10; last_trdy = 1'b1;
            end
          end else begin
            if (spi_reg_addr == 8'h0D) begin
              check("trdy_seen", last_trdy, 1);
              last_trdy = 1'b0;
              tx_writes++;
              if (first_tx_cyc < 0) begin first_tx_cyc = cyc; reads_first = sr_reads; end
            end
            if (sb.size() == 0) check("extra_write", sb.size(), 1);
            else begin
              expv = sb.pop_front();
              check("write", {dc, spi_reg_addr, spi_data_in}, expv);
            end
          end
        end
      end else if (!spi_strobe) begin
        low_cnt++;
      end
    end
  end

  task automatic push_expected();
    logic [8:0] scr [18];
    scr = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h029, 9'h02A, 9'h100,
            9'h100, {1'b1, X[15:8]}, {1'b1, X[7:0]}, 9'h02B, 9'h100, 9'h100,
            {1'b1, Y[15:8]}, {1'b1, Y[7:0]}, 9'h02C};
    sb.push_back({1'b0, 8'h09, 8'h80});
    sb.push_back({1'b0, 8'h0A, 8'hC0});
    sb.push_back({1'b0, 8'h0B, 8'h00});
    for (int i = 0; i < 18; i++) sb.push_back({scr[i][8], 8'h0D, scr[i][7:0]});
    for (int i = 0; i < int'(X) * int'(Y); i++) begin
      sb.push_back({1'b1, 8'h0D, 8'hF8});
      sb.push_back({1'b1, 8'h0D, 8'h00});
    end
  endtask

  // called on a falling edge
  task automatic start_run();
    push_expected();
    poll_zero = 3; rise_cyc = -1; first_tx_cyc = -1; reads_first = -1;
    tx_writes = 0; sr_reads = 0; rel_cyc = cyc;
    reset = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < LIMIT && sb.size() != 0; i++) @(posedge clk);
    check("queue_drained", sb.size(), 0);
    check("tx_count", tx_writes, 2 * 18 / 2 + 2 * int'(X) * int'(Y));
  endtask

  int n0;
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dis_reset", dis_reset, 0);
    check("rst_tx_busy", tx_busy, 1);
    check("rst_strobe", spi_strobe, 0);
    check("rst_dc", dc, 0);

    // run 1: full sequence, later bytes with slow ack
    start_run();
    for (int i = 0; i < LIMIT && rise_cyc < 0; i++) @(posedge clk);
    check("dis_reset_rise", rise_cyc - rel_cyc, 100);
    for (int i = 0; i < LIMIT && tx_writes < 20; i++) @(posedge clk);
    ack_dly = 10;
    wait_drain();
    check("first_tx_gap", (first_tx_cyc - rise_cyc) >= 100, 1);
    check("poll_retries", reads_first, 4);
    n0 = txn_starts;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("done_idle", txn_starts - n0, 0);
    check("done_dis_reset", dis_reset, 1);
    check("done_busy", tx_busy, 0);

    // run 2: reset pulse in the middle of the frame
    ack_dly = 2;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    start_run();
    for (int i = 0; i < LIMIT && tx_writes < 25; i++) @(posedge clk);
    check("reached_frame", tx_writes >= 25, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_strobe", spi_strobe, 0);
    check("midrst_dis_reset", dis_reset, 0);
    check("midrst_busy", tx_busy, 1);
    repeat (3) @(negedge clk);
    sb.delete();
    start_run();
    wait_drain();
    check("rerun_poll_retries", reads_first, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_spi_frame_writer.md
# lcd_spi_frame_writer

Drives an ILI9341-class SPI LCD through the iCE40UP5K hard SPI block (SB_SPI) system bus. It has two internal sections:
- A display sequencer: panel hardware reset, command/data init script, then one full frame of solid red RGB565 pixels.
- A bus master: configures SB_SPI, then pushes each byte through SPITXDR after polling TRDY.

It sits between the fabric and the SB_SPI primitive; `dis_reset` and `dc` go straight to panel pins.

## Interface
- `DIS_RES_X`, 240: panel width in pixels (16-bit).
- `DIS_RES_Y`, 320: panel height in pixels (16-bit).
- `HW_RESET_TIMER`, 1200000: cycles for each hardware-reset phase.
- `SW_RESET_TIMER`, 600000: cycles waited after software reset.
- `SLEEP_OUT_TIMER`, 600000: cycles waited after sleep out.
- `DISPLAY_ON_TIMER`, 600000: cycles waited after display on.
- `SPI_CLK_DIVIDER`, 1: SPIBR divider value (≥1).
- `SPI_ADDR_BASE`, 4'h0: upper nibble of all SB_SPI register addresses.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: reset is asynchronous and active-low.
- `spi_strobe` out 1: SB_SPI SBSTBI.
- `spi_rw` out 1: 1 = write, 0 = read.
- `spi_reg_addr` out 8: SB_SPI register address.
- `spi_data_in` out 8: write data to SB_SPI.
- `spi_data_out` in 8: read data from SB_SPI.
- `spi_ack` in 1: SB_SPI SBACKO.
- `dis_reset` out 1: panel RESX, active low.
- `dc` out 1: panel D/C; 0 = command, 1 = data.
- `tx_busy` out 1: byte path not ready for a new byte.

## Operation
- SB_SPI register offsets, added to `{SPI_ADDR_BASE,4'h0}`: SPICR1 = 0x9, SPICR2 = 0xA, SPIBR = 0xB, SPISR = 0xC, SPITXDR = 0xD. TRDY is SPISR bit 4.
- While reset is asserted: `dis_reset`=0, `tx_busy`=1, `spi_strobe`=0, `dc`=0, and all timers are cleared.
- Bus master config after reset release, all writes:
  - SPICR1 ← 0x80.
  - SPICR2 ← 0xC0 (master mode).
  - SPIBR ← `SPI_CLK_DIVIDER`-1.
  - `tx_busy` drops to 0 only after the config writes complete.
- Byte send, started by the internal `tx_start` with `tx_data`:
  - `tx_busy` goes to 1.
  - Read SPISR repeatedly until bit 4 = 1.
  - Write `tx_data` to SPITXDR.
  - `tx_busy` goes to 0.
- Sequencer, after reset release:
  1. Hold `dis_reset`=0 for `HW_RESET_TIMER` cycles.
  2. Drive `dis_reset`=1 and wait `HW_RESET_TIMER` cycles.
  3. Send the script below; each byte waits for `tx_busy`=0 first.
- Init script:
  - cmd 0x01 (SW reset), wait `SW_RESET_TIMER`.
  - cmd 0x11 (sleep out), wait `SLEEP_OUT_TIMER`.
  - cmd 0x3A, data 0x55 (RGB565).
  - cmd 0x36, data 0x48.
  - cmd 0x29 (display on), wait `DISPLAY_ON_TIMER`.
  - cmd 0x2A, data 0x00, 0x00, `DIS_RES_X[15:8]`, `DIS_RES_X[7:0]`.
  - cmd 0x2B, data 0x00, 0x00, `DIS_RES_Y[15:8]`, `DIS_RES_Y[7:0]`.
  - cmd 0x2C.
- Frame: `DIS_RES_X`*`DIS_RES_Y` pixels, each as data 0xF8 then 0x00. Pixel counter is 32-bit.
- After the last pixel byte, enter DONE: idle permanently, `dis_reset`=1, no further strobes.
- `dc` is set to the byte's kind before `tx_start` and held until that byte's SPITXDR write is acknowledged.
- Post-command waits start when `tx_busy` falls after that command.

## Timing
- Bus cycle:
  - Assert `spi_strobe` with `spi_rw`, `spi_reg_addr` and `spi_data_in` stable.
  - Hold all of them until the first cycle `spi_ack`=1.
  - Deassert `spi_strobe` on the next edge; it stays low at least one cycle before the next transaction.
- Read data is sampled from `spi_data_out` in the ack cycle.
- No timeout on `spi_ack`.
- `tx_start` is ignored while `tx_busy`=1. `tx_busy` rises the cycle after an accepted `tx_start`.
- Reset mid-operation aborts everything: back to HW-reset phase 1 with `dis_reset`=0 and `spi_strobe` dropped immediately.

## Test plan
- Hold reset asserted 1 cycle, with an SB_SPI model acking 2 cycles after each strobe and returning 0x10 for reads → `dis_reset`=0 and `tx_busy`=1 during reset. After release, SPICR1/SPICR2/SPIBR writes are 0x80/0xC0/0x00.
- HW_RESET_TIMER=100, other timers small → `dis_reset` rises 100 cycles after release. The first SPITXDR write (data 0x01, `dc`=0) occurs ≥100 cycles later.
- X=4, Y=3 → SPITXDR write sequence is exactly 01,11,3A,55,36,48,29,2A,00,00,00,04,2B,00,00,00,03,2C, then 24 bytes alternating F8,00. `dc`=0 on commands, 1 on data.
- SPISR model returns 0x00 for N reads, then 0x10 → no SPITXDR write until TRDY is seen. `tx_busy` stays 1 throughout.
- Ack delayed 10 cycles → strobe and address held stable for all 10 cycles; strobe low ≥1 cycle between transactions.
- Reset pulse mid-frame → strobe drops, `dis_reset`=0, and the full sequence restarts from 0x01.
